// File: rtl/divisor_subtrai_desloca.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : divisor_subtrai_desloca                                    |
// | Description : Sequential restoring divider (shift-and-subtract).         |
// |               Divides an N-bit unsigned dividend by an N-bit unsigned    |
// |               divisor and produces one quotient bit per clock.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk        in   1  system clock, rising-edge active                    |
// |   rst_n      in   1  asynchronous active-low reset                       |
// |   dividendo  in   N  unsigned dividend, sampled on the start edge        |
// |   divisor    in   N  unsigned divisor, sampled on the start edge         |
// |   st         in   1  start request, level-sampled only while idle        |
// |   quociente  out  N  quotient, held until the next start edge            |
// |   resto      out  N  remainder, held until the next start edge          |
// |   done       out  1  one-cycle pulse marking a completed result         |
// |   idle       out  1  high while a new start can be accepted             |
// |   div_zero   out  1  captured divisor was zero; held to next start      |
// +--------------------------------------------------------------------------+
module divisor_subtrai_desloca #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  input  logic         st,
  output logic [N-1:0] quociente,
  output logic [N-1:0] resto,
  output logic         done,
  output logic         idle,
  output logic         div_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [N:0]    r_a;      // partial remainder
  logic [N-1:0]  r_q;      // dividend bits shifting out / quotient bits shifting in
  logic [N-1:0]  r_b;      // captured divisor
  logic [N-1:0]  r_quoc;
  logic [N-1:0]  r_resto;
  logic          r_dz;

  logic [N:0]    w_a_sh;
  logic [N:0]    w_trial;
  logic [N:0]    w_a_new;
  logic          w_fits;
  logic [N-1:0]  w_q_new;

  // One restoring step: shift {A,Q} left, try subtracting B, keep the
  // difference only when it is non-negative.
  always_comb begin
    w_a_sh  = {r_a[N-1:0], r_q[N-1]};
    w_trial = w_a_sh - {1'b0, r_b};
    // r_a[N] is the bit shifted out of A. Since A < B between steps it is
    // always 0, but folding it in keeps the comparison exact regardless.
    w_fits  = ~w_trial[N] | r_a[N];
    w_a_new = w_fits ? w_trial : w_a_sh;
    w_q_new = {r_q[N-2:0], w_fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_quoc  <= '0;
      r_resto <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (st) begin
            r_b   <= divisor;
            r_q   <= dividendo;
            r_a   <= '0;
            r_cnt <= CW'(N);
            r_dz  <= 1'b0;
            if (divisor == '0) begin
              // No iterations: report saturated quotient and pass the
              // dividend through as the remainder.
              r_dz    <= 1'b1;
              r_quoc  <= '1;
              r_resto <= dividendo;
              r_state <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_a   <= w_a_new;
          r_q   <= w_q_new;
          r_cnt <= r_cnt - CW'(1);
          // Last iteration publishes the freshly computed step directly.
          if (r_cnt == CW'(1)) begin
            r_quoc  <= w_q_new;
            r_resto <= w_a_new[N-1:0];
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign quociente = r_quoc;
  assign resto     = r_resto;
  assign div_zero  = r_dz;
  assign done      = (r_state == S_DONE);
  assign idle      = (r_state == S_IDLE);

endmodule
`default_nettype wire
